// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// instr_fetch_pkg : shared fetch-stage widths, FSM encoding and helpers
// Revision 1.0
// ============================================================================
package instr_fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : single-outstanding instruction fetch with redirect and stall
// Revision 1.0
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pending_pc_q, pending_pc_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

    logic [XLEN-1:0] redirect_tgt;
    logic [XLEN-1:0] pc_inc;

    assign redirect_tgt = word_align(redirect_pc_i);
    assign pc_inc       = pc_q + XLEN'(4);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_pc_d = pending_pc_q;
        instr_d      = instr_q;
        pc_plus4_d   = pc_plus4_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_i) pc_d = redirect_tgt;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_i) begin
                    // A response arriving with the redirect frees the port, so refetch directly.
                    if (imem_rvalid_i) begin
                        pc_d = redirect_tgt;
                    end else begin
                        pending_pc_d = redirect_tgt;
                        state_d      = ST_DRAIN;
                    end
                end else if (imem_rvalid_i) begin
                    instr_d    = imem_rdata_i;
                    pc_plus4_d = pc_inc;
                    pc_d       = pc_inc;
                    state_d    = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid_i) begin
                    pc_d    = redirect_i ? redirect_tgt : pending_pc_q;
                    state_d = ST_REQ;
                end else if (redirect_i) begin
                    pending_pc_d = redirect_tgt;
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    pc_d    = redirect_tgt;
                    state_d = ST_REQ;
                end else if (!stall_i) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            pending_pc_q <= '0;
            instr_q      <= '0;
            pc_plus4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
            instr_q      <= instr_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    assign imem_req_o  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign imem_addr_o = pc_q;
    assign valid_o     = (state_q == ST_HOLD);
    assign instr_o     = instr_q;
    assign pc_plus4_o  = pc_plus4_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch : directed + randomized bench with memory responder and
// instruction-stream reference model
// Revision 1.0
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req, imem_rvalid, redirect, stall, valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, pc_plus4;

    logic        mem_rvalid, inj_rvalid;
    logic [31:0] mem_rdata;
    int          lat_cfg;

    logic        rst2_n, req2, rvalid2, valid2, redirect2, stall2;
    logic [31:0] addr2, rdata2, instr2, pp4_2, redirect_pc2;

    int checks   = 0;
    int failures = 0;

    logic [31:0] req_log[$];
    logic [31:0] pp4_log[$];

    assign imem_rvalid = mem_rvalid | inj_rvalid;
    assign imem_rdata  = inj_rvalid ? 32'h1234_5678 : mem_rdata;

    instr_fetch dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .stall_i       (stall),
        .instr_o       (instr),
        .pc_plus4_o    (pc_plus4),
        .valid_o       (valid)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i         (clk),
        .rst_i         (rst2_n),
        .imem_req_o    (req2),
        .imem_addr_o   (addr2),
        .imem_rvalid_i (rvalid2),
        .imem_rdata_i  (rdata2),
        .redirect_i    (redirect2),
        .redirect_pc_i (redirect_pc2),
        .stall_i       (stall2),
        .instr_o       (instr2),
        .pc_plus4_o    (pp4_2),
        .valid_o       (valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2008_FFFF ^ a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: one transaction at a time, latency 1..3 cycles
    logic [31:0] cap_addr;
    logic        busy;
    int          cnt;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            busy       = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hDEAD_BEEF;
        end else begin
            if (mem_rvalid) begin
                mem_rvalid = 1'b0;
                mem_rdata  = 32'hDEAD_BEEF;
                busy       = 1'b0;
            end else if (busy) begin
                check("req_held", {31'b0, imem_req}, 32'd1);
                check("addr_stable", imem_addr, cap_addr);
                cnt--;
            end
            if (!busy && imem_req) begin
                busy     = 1'b1;
                cap_addr = imem_addr;
                req_log.push_back(imem_addr);
                cnt      = ((lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg) - 1;
            end
            if (busy && cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(cap_addr);
            end
        end
    end

    // Reference model: address of the next instruction the stream must deliver
    logic [31:0] exp_pc;
    logic        held;
    int          idle_cnt;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc   = 32'h0;
            held     = 1'b0;
            idle_cnt = 0;
        end else begin
            if (held) check("hold_valid", {31'b0, valid}, 32'd1);
            if (valid) begin
                check("instr", instr, mem_word(exp_pc));
                check("pc_plus4", pc_plus4, exp_pc + 32'd4);
                if (!held) pp4_log.push_back(pc_plus4);
                idle_cnt = 0;
            end else begin
                idle_cnt++;
                if (idle_cnt > 60) begin
                    check("progress_timeout", 32'(idle_cnt), 32'd0);
                    idle_cnt = 0;
                end
            end
            check("req_valid_excl", {31'b0, valid & imem_req}, 32'd0);
            held = valid && !redirect && stall;
            if (redirect)             exp_pc = redirect_pc & 32'hFFFF_FFFC;
            else if (valid && !stall) exp_pc = exp_pc + 32'd4;
        end
    end

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int max, input string tag);
        int n = 0;
        while (!valid && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, valid}, 32'd1);
    endtask

    task automatic wait_reqs(input int target, input int max, input string tag);
        int n = 0;
        while (req_log.size() < target && n < max) begin
            @(negedge clk);
            check({tag, "_valid_low"}, {31'b0, valid}, 32'd0);
            n++;
        end
        check({tag, "_req_count"}, 32'(req_log.size()), 32'(target));
    endtask

    int n0, p0;
    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        inj_rvalid = 1'b0; lat_cfg = 1;
        rst2_n = 1'b0; rvalid2 = 1'b0; rdata2 = '0; redirect2 = 1'b0;
        redirect_pc2 = '0; stall2 = 1'b0;
        #12;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pp4", pc_plus4, 32'd0);

        // Sequential fetch at latency 1
        n0 = req_log.size(); p0 = pp4_log.size();
        @(negedge clk) rst_n = 1'b1;
        #1 check("idle_no_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'd0);
        repeat (5) @(negedge clk);
        #1;
        check("seq_pulses", 32'(pp4_log.size() - p0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("seq_addr", req_log[n0 + i], 32'(4 * i));
            check("seq_pp4", pp4_log[p0 + i], 32'(4 * (i + 1)));
        end

        // Stall holds the first instruction
        @(posedge clk) #1 stall = 1'b1;
        do_reset();
        wait_valid(20, "stall_wait");
        n0 = req_log.size();
        repeat (5) begin
            @(negedge clk);
            check("stall_instr", instr, 32'h2008_FFFF);
            check("stall_pp4", pc_plus4, 32'd4);
            check("stall_valid", {31'b0, valid}, 32'd1);
            check("stall_noreq", {31'b0, imem_req}, 32'd0);
        end
        check("stall_no_new_req", 32'(req_log.size()), 32'(n0));
        @(posedge clk) #1 stall = 1'b0;

        // Reset in the middle of an outstanding request, late strobe in IDLE
        lat_cfg = 3;
        n0 = 0;
        while (!imem_req && n0 < 20) begin @(negedge clk); n0++; end
        rst_n = 1'b0;
        #1;
        check("async_rst_req", {31'b0, imem_req}, 32'd0);
        check("async_rst_valid", {31'b0, valid}, 32'd0);
        check("async_rst_instr", instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; inj_rvalid = 1'b1;
        @(posedge clk) #1 inj_rvalid = 1'b0;
        @(negedge clk) check("late_rvalid_ignored", {31'b0, valid}, 32'd0);
        wait_valid(30, "after_rst_wait");
        check("after_rst_pp4", pc_plus4, 32'd4);

        // Redirect while REQ at latency 3
        @(posedge clk) #1;
        do_reset();
        n0 = req_log.size();
        @(posedge clk) #1 begin redirect = 1'b1; redirect_pc = 32'h0000_0103; end
        @(posedge clk) #1 redirect = 1'b0;
        wait_reqs(n0 + 2, 20, "redir_req");
        check("redir_old_addr", req_log[n0], 32'h0);
        check("redir_new_addr", req_log[n0 + 1], 32'h0000_0100);
        wait_valid(20, "redir_wait");
        check("redir_pp4", pc_plus4, 32'h0000_0104);

        // Two redirects while draining: latest wins
        do_reset();
        n0 = req_log.size();
        @(posedge clk) #1 begin redirect = 1'b1; redirect_pc = 32'h40; end
        @(posedge clk) #1 redirect_pc = 32'h80;
        @(posedge clk) #1 redirect = 1'b0;
        wait_reqs(n0 + 2, 20, "drain_req");
        check("drain_addr", req_log[n0 + 1], 32'h80);

        // Redirect out of HOLD
        lat_cfg = 1;
        @(posedge clk) #1 stall = 1'b1;
        do_reset();
        wait_valid(20, "hold_wait");
        n0 = req_log.size();
        @(posedge clk) #1 begin redirect = 1'b1; redirect_pc = 32'h20; stall = 1'b0; end
        @(posedge clk) #1 redirect = 1'b0;
        @(negedge clk);
        check("hold_redir_valid", {31'b0, valid}, 32'd0);
        check("hold_redir_req", {31'b0, imem_req}, 32'd1);
        check("hold_redir_addr", imem_addr, 32'h20);
        check("hold_redir_log", 32'(req_log.size()), 32'(n0 + 1));

        // Randomized traffic against the stream model
        lat_cfg = 0;
        repeat (800) begin
            @(posedge clk) #1;
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
            stall       = ($urandom_range(0, 2) == 0);
        end
        @(posedge clk) #1 begin redirect = 1'b0; stall = 1'b0; end
        repeat (4) @(negedge clk);

        // Wrap-around from RESET_PC = 0xFFFF_FFFC
        @(negedge clk) rst2_n = 1'b1;
        n0 = 0;
        while (!req2 && n0 < 5) begin @(negedge clk); n0++; end
        check("wrap_first_addr", addr2, 32'hFFFF_FFFC);
        rvalid2 = 1'b1; rdata2 = 32'h0000_0013;
        @(negedge clk);
        rvalid2 = 1'b0;
        check("wrap_valid", {31'b0, valid2}, 32'd1);
        check("wrap_pp4", pp4_2, 32'h0);
        check("wrap_instr", instr2, 32'h0000_0013);
        @(negedge clk);
        check("wrap_next_req", {31'b0, req2}, 32'd1);
        check("wrap_next_addr", addr2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
